norm_round_seq: RTL

- Inverse of the partial-product alignment stage. It takes an accumulated two's-complement sum of aligned partial products, plus the max exponent the products were aligned to.
- Converts the sum back to sign/exponent/mantissa in the same low-precision format the aligner consumes (hidden one plus MAN_W fraction bits).
- Sits after the MAC adder tree; iterative one-bit-per-cycle normaliser with valid/ready handshakes on both sides.

---
 rtl/mac_pkg.sv | 31 +++
 rtl/rne_round.sv | 65 ++++++
 rtl/norm_round_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: normaliser FSM states, alignment
// geometry and the cell-count helper used by the constant `number` ports.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Bit of the aligned sum that carries weight 2^0 relative to max_exp.
    localparam int ALIGN_ONE_BIT = 13;
    // Width of one aligned partial product before accumulation growth.
    localparam int PP_W          = 15;
    // Stored exponent width, and the one-bit-wider internal working exponent.
    localparam int EXP_W         = 6;
    localparam int EXPI_W        = EXP_W + 1;
    // Width of the constant cell-count metric port.
    localparam int NUMBER_W      = 51;

    // Gate weights of the ADD (one full-adder bit) and INV primitives.
    localparam int ADD_CELL_GATES = 5;
    localparam int INV_CELL_GATES = 1;

    function automatic logic [NUMBER_W-1:0] cell_gates(input int n_add, input int n_inv);
        return NUMBER_W'(n_add * ADD_CELL_GATES + n_inv * INV_CELL_GATES);
    endfunction

endpackage

// File: rtl/rne_round.sv
// Combinational round-to-nearest-even of a normalised magnitude into
// hidden-one + MAN_W fraction bits, with exponent carry and saturation.
module rne_round
    import mac_pkg::*;
#(
    parameter int SUM_W = 18,
    parameter int MAN_W = 2
) (
    input  logic [SUM_W-1:0]    i_mag,
    input  logic [EXPI_W-1:0]   i_exp_w,
    output logic [MAN_W-1:0]    o_man,
    output logic [EXP_W-1:0]    o_exp,
    output logic                o_of,
    output logic [NUMBER_W-1:0] number
);

    // Round bit sits just below the kept fraction; everything under it is sticky.
    localparam int                 R_POS       = SUM_W - 2 - MAN_W;
    localparam int                 FRAC_W      = MAN_W + 1;
    localparam logic [SUM_W-1:0]   STICKY_MASK = (SUM_W'(1) << R_POS) - SUM_W'(1);
    localparam logic [EXPI_W-1:0]  EXP_MAX     = EXPI_W'((1 << EXP_W) - 1);

    function automatic logic rne_inc(input logic lsb, input logic rnd, input logic sticky);
        return rnd & (sticky | lsb);
    endfunction

    function automatic logic exp_sat(input logic [EXPI_W-1:0] exp_w);
        return exp_w > EXP_MAX;
    endfunction

    // The hidden one is implied by normalisation and is not part of the result.
    logic               hidden_unused;
    logic [MAN_W-1:0]   frac;
    logic               rnd_bit;
    logic               sticky_bit;
    logic [MAN_W:0]     frac_inc;
    logic [EXPI_W-1:0]  exp_rnd;

    assign hidden_unused = i_mag[SUM_W-1];

    // Round the fraction, propagate carry into the exponent, saturate on overflow
    always_comb begin
        o_of       = 1'b0;
        o_exp      = '0;
        o_man      = '0;
        frac       = i_mag[SUM_W-2 -: MAN_W];
        rnd_bit    = i_mag[R_POS];
        sticky_bit = |(i_mag & STICKY_MASK);
        frac_inc   = {1'b0, frac} + FRAC_W'(rne_inc(frac[0], rnd_bit, sticky_bit));
        // A carry out of the fraction leaves the low bits at zero and bumps the exponent.
        exp_rnd    = i_exp_w + EXPI_W'(frac_inc[MAN_W]);
        if (exp_sat(exp_rnd)) begin
            o_of  = 1'b1;
            o_exp = '1;
            o_man = '1;
        end else begin
            o_exp = exp_rnd[EXP_W-1:0];
            o_man = frac_inc[MAN_W-1:0];
        end
    end

    // Fraction incrementer plus exponent incrementer.
    assign number = cell_gates(MAN_W + EXPI_W, 0);

endmodule

// File: rtl/norm_round_seq.sv
// Iterative normaliser: turns an accumulated two's-complement aligned sum back
// into sign / exponent / rounded mantissa, one shift decision per cycle.
module norm_round_seq
    import mac_pkg::*;
#(
    parameter  int GUARD = 3,
    parameter  int MAN_W = 2,
    localparam int SUM_W = PP_W + GUARD
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SUM_W-1:0]    i_sum,
    input  logic [EXP_W-1:0]    i_max_exp,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_sign,
    output logic [EXP_W-1:0]    o_exp,
    output logic [MAN_W-1:0]    o_man,
    output logic                o_zero,
    output logic                o_of,
    output logic                o_uf,
    output logic [NUMBER_W-1:0] number
);

    // The sum MSB sits GUARD+1 binary places above the 2^0 bit, so the working
    // exponent starts that much above max_exp and counts down with each shift.
    localparam logic [EXPI_W-1:0] EXP_OFFSET = EXPI_W'(GUARD + 1);

    state_e              state_q, state_d;
    logic [SUM_W-1:0]    mag_q, mag_d;
    logic [EXPI_W-1:0]   expw_q, expw_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [MAN_W-1:0]    man_q, man_d;
    logic                zero_q, zero_d;
    logic                of_q, of_d;
    logic                uf_q, uf_d;

    logic [MAN_W-1:0]    rnd_man;
    logic [EXP_W-1:0]    rnd_exp;
    logic                rnd_of;
    logic [NUMBER_W-1:0] rnd_number;

    rne_round #(
        .SUM_W (SUM_W),
        .MAN_W (MAN_W)
    ) u_rne_round (
        .i_mag   (mag_q),
        .i_exp_w (expw_q),
        .o_man   (rnd_man),
        .o_exp   (rnd_exp),
        .o_of    (rnd_of),
        .number  (rnd_number)
    );

    assign o_ready = (state_q == ST_IDLE) && !i_rst;
    assign o_valid = (state_q == ST_DONE);
    assign o_sign  = sign_q;
    assign o_exp   = exp_q;
    assign o_man   = man_q;
    assign o_zero  = zero_q;
    assign o_of    = of_q;
    assign o_uf    = uf_q;

    // Abs-value negator (INV + ADD per bit) and the offset / decrement exponent adders.
    assign number  = rnd_number + cell_gates(SUM_W + 2 * EXPI_W, SUM_W);

    // Next state, working magnitude/exponent and result fields
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        expw_d  = expw_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        man_d   = man_q;
        zero_d  = zero_q;
        of_d    = of_q;
        uf_d    = uf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid && o_ready) begin
                    state_d = ST_ABS;
                    mag_d   = i_sum;
                    expw_d  = {1'b0, i_max_exp};
                    sign_d  = 1'b0;
                    exp_d   = '0;
                    man_d   = '0;
                    zero_d  = 1'b0;
                    of_d    = 1'b0;
                    uf_d    = 1'b0;
                end
            end
            ST_ABS: begin
                // Magnitude stays SUM_W unsigned, so the most negative sum maps to 2^(SUM_W-1) exactly.
                sign_d = mag_q[SUM_W-1];
                mag_d  = mag_q[SUM_W-1] ? -mag_q : mag_q;
                expw_d = expw_q + EXP_OFFSET;
                if (mag_q == '0) begin
                    zero_d  = 1'b1;
                    sign_d  = 1'b0;
                    exp_d   = '0;
                    man_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Normalisation wins over underflow when both happen on the same cycle.
                if (mag_q[SUM_W-1]) begin
                    state_d = ST_ROUND;
                end else if (expw_q == '0) begin
                    uf_d    = 1'b1;
                    zero_d  = 1'b1;
                    sign_d  = 1'b0;
                    exp_d   = '0;
                    man_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    mag_d  = {mag_q[SUM_W-2:0], 1'b0};
                    expw_d = expw_q - EXPI_W'(1);
                end
            end
            ST_ROUND: begin
                man_d   = rnd_man;
                exp_d   = rnd_exp;
                of_d    = rnd_of;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and visible result fields, cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            zero_q  <= 1'b0;
            of_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            man_q   <= man_d;
            zero_q  <= zero_d;
            of_q    <= of_d;
            uf_q    <= uf_d;
        end
    end

    // Working magnitude and exponent; always reloaded on accept, so no reset needed
    always_ff @(posedge i_clk) begin
        mag_q  <= mag_d;
        expw_q <= expw_d;
    end

endmodule
